// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, back-half pipeline
// register layouts and the data-memory access state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam word_t WORD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HALTED
    } mem_state_t;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic     valid;
        logic     RegWr;
        logic     MemToReg;
        logic     dREN;
        logic     dWEN;
        logic     halt;
        regbits_t wsel;
        word_t    aluout;
        word_t    storedata;
    } exmem_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic     valid;
        logic     RegWr;
        regbits_t wsel;
        word_t    wdat;
    } memwb_t;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic word_t sat_inc(input word_t v);
        return (v == WORD_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_mem_wb_stage_mem_access_fsm.sv
// Data-memory access sequencer for the MEM stage: owns the IDLE/ACCESS/HALTED
// state, the registered request strobes and the upstream stall.
module mem_access_fsm
    import cpu_types_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic dhit_i,
    input  logic nxt_ren_i,    // entry being loaded into EX/MEM is a valid load
    input  logic nxt_wen_i,    // entry being loaded into EX/MEM is a valid store
    input  logic halt_cap_i,   // MEM/WB is capturing a valid halt this edge
    output logic access_o,
    output logic halted_o,
    output logic mem_stall_o,
    output logic done_o,
    output logic dmem_ren_o,
    output logic dmem_wen_o
);

    mem_state_t state_q;
    logic       ren_q;
    logic       wen_q;
    logic       loading;

    assign access_o    = (state_q == ACCESS);
    assign halted_o    = (state_q == HALTED);
    assign mem_stall_o = halted_o | (access_o & ~dhit_i);
    assign loading     = ~mem_stall_o;
    assign done_o      = access_o & dhit_i;
    assign dmem_ren_o  = access_o & ren_q;
    assign dmem_wen_o  = access_o & wen_q;

    // State and request registers advance only on edges where EX/MEM loads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCESS: begin
                    if (loading) begin
                        if (halt_cap_i) begin
                            state_q <= HALTED;
                            ren_q   <= 1'b0;
                            wen_q   <= 1'b0;
                        end else if (nxt_ren_i | nxt_wen_i) begin
                            state_q <= ACCESS;
                            ren_q   <= nxt_ren_i;
                            wen_q   <= nxt_wen_i;
                        end else begin
                            state_q <= IDLE;
                            ren_q   <= 1'b0;
                            wen_q   <= 1'b0;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_wb_stage.sv
// Back half of the five-stage pipeline: EX/MEM and MEM/WB registers, data
// memory sequencing, forwarding-unit taps and register-file write port.
// Optional macro MEM_STAGE_STATS_EN adds stall_cycles / mem_ops counters.
module ex_mem_wb_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_RegWr,
    input  logic        ex_MemToReg,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_halt,
    input  logic [4:0]  ex_wsel,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_storedata,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic [4:0]  MEMwsel,
    output logic        MEMRegWr,
    output logic [31:0] MEMresult,
    output logic [4:0]  WBwsel,
    output logic        WBRegWr,
    output logic [31:0] wb_wdat,
    output logic        wb_halt
`ifdef MEM_STAGE_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] mem_ops
`endif
);

    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic in_access;
    logic halted;
    logic done;
    logic retire;
    logic halt_cap;
    logic nxt_ren;
    logic nxt_wen;

    // EX/MEM advances (and its entry retires into MEM/WB) whenever not stalled
    assign retire   = ~mem_stall;
    assign halt_cap = retire & exmem_q.valid & exmem_q.halt;
    assign nxt_ren  = ~flush & ex_valid & ex_dREN;
    assign nxt_wen  = ~flush & ex_valid & ex_dWEN;

    mem_access_fsm u_fsm (
        .clk_i       (CLK),
        .rst_ni      (nRST),
        .dhit_i      (dhit),
        .nxt_ren_i   (nxt_ren),
        .nxt_wen_i   (nxt_wen),
        .halt_cap_i  (halt_cap),
        .access_o    (in_access),
        .halted_o    (halted),
        .mem_stall_o (mem_stall),
        .done_o      (done),
        .dmem_ren_o  (dmemREN),
        .dmem_wen_o  (dmemWEN)
    );

    // Next EX/MEM contents: hold while stalled, bubble on flush
    always_comb begin
        exmem_d = exmem_q;
        if (retire) begin
            if (flush) begin
                exmem_d = '0;
            end else begin
                exmem_d.valid     = ex_valid;
                exmem_d.RegWr     = ex_RegWr;
                exmem_d.MemToReg  = ex_MemToReg;
                exmem_d.dREN      = ex_dREN;
                exmem_d.dWEN      = ex_dWEN;
                exmem_d.halt      = ex_halt;
                exmem_d.wsel      = ex_wsel;
                exmem_d.aluout    = ex_aluout;
                exmem_d.storedata = ex_storedata;
            end
        end
    end

    // Next MEM/WB contents: retiring entry passes through, anything else is a bubble
    always_comb begin
        memwb_d = '0;
        if (retire) begin
            memwb_d.valid = exmem_q.valid;
            memwb_d.RegWr = exmem_q.RegWr & ~exmem_q.dWEN;
            memwb_d.wsel  = exmem_q.wsel;
            memwb_d.wdat  = (in_access & exmem_q.dREN) ? dmemload : exmem_q.aluout;
        end
    end

    // Pipeline registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign dmemaddr  = in_access ? exmem_q.aluout    : '0;
    assign dmemstore = in_access ? exmem_q.storedata : '0;

    // Loads are not forwardable from MEM: their data only exists at WB
    assign MEMwsel   = exmem_q.wsel;
    assign MEMRegWr  = exmem_q.valid & exmem_q.RegWr & ~exmem_q.MemToReg;
    assign MEMresult = exmem_q.aluout;

    assign WBwsel    = memwb_q.wsel;
    assign WBRegWr   = memwb_q.valid & memwb_q.RegWr;
    assign wb_wdat   = memwb_q.wdat;
    assign wb_halt   = halted;

`ifdef MEM_STAGE_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] mem_ops_q;

    // Saturating activity counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
            mem_ops_q      <= '0;
        end else begin
            if (mem_stall & ~halted) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
            if (done) begin
                mem_ops_q <= sat_inc(mem_ops_q);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_ops      = mem_ops_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Self-checking bench for ex_mem_wb_stage: transaction-level reference model
// compared every cycle, plus directed hand-computed expectations.
module tb_ex_mem_wb_stage;

    logic        CLK;
    logic        nRST;
    logic        ex_valid, ex_RegWr, ex_MemToReg, ex_dREN, ex_dWEN, ex_halt;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_aluout, ex_storedata;
    logic        flush, dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall, MEMRegWr, WBRegWr, wb_halt;
    logic [31:0] dmemaddr, dmemstore, MEMresult, wb_wdat;
    logic [4:0]  MEMwsel, WBwsel;
`ifdef MEM_STAGE_STATS_EN
    logic [31:0] stall_cycles, mem_ops;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    ex_mem_wb_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ex_valid     (ex_valid),
        .ex_RegWr     (ex_RegWr),
        .ex_MemToReg  (ex_MemToReg),
        .ex_dREN      (ex_dREN),
        .ex_dWEN      (ex_dWEN),
        .ex_halt      (ex_halt),
        .ex_wsel      (ex_wsel),
        .ex_aluout    (ex_aluout),
        .ex_storedata (ex_storedata),
        .flush        (flush),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .mem_stall    (mem_stall),
        .MEMwsel      (MEMwsel),
        .MEMRegWr     (MEMRegWr),
        .MEMresult    (MEMresult),
        .WBwsel       (WBwsel),
        .WBRegWr      (WBRegWr),
        .wb_wdat      (wb_wdat),
        .wb_halt      (wb_halt)
`ifdef MEM_STAGE_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .mem_ops      (mem_ops)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Instruction sitting in MEM and instruction sitting in WB, plus whether
    // the MEM instruction is waiting on the data cache, plus halt status.
    typedef struct packed {
        logic        v, rw, m2r, rd, wr, hlt;
        logic [4:0]  sel;
        logic [31:0] alu, st;
    } mem_ent_t;

    typedef struct packed {
        logic        v, rw;
        logic [4:0]  sel;
        logic [31:0] wd;
    } wb_ent_t;

    mem_ent_t m_mem;
    wb_ent_t  m_wb;
    bit       m_waiting;
    bit       m_halted;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_mem = '0;
            m_wb = '0;
            m_waiting = 0;
            m_halted = 0;
        end else if (m_halted) begin
            m_wb = '0;
        end else if (m_waiting && !dhit) begin
            m_wb = '0;
        end else begin
            // MEM instruction moves to WB; stores never write, loads take cache data
            m_wb.v   = m_mem.v;
            m_wb.rw  = m_mem.rw && !m_mem.wr;
            m_wb.sel = m_mem.sel;
            m_wb.wd  = (m_waiting && m_mem.rd) ? dmemload : m_mem.alu;
            if (m_mem.v && m_mem.hlt) m_halted = 1;
            if (flush) m_mem = '0;
            else m_mem = '{ex_valid, ex_RegWr, ex_MemToReg, ex_dREN, ex_dWEN, ex_halt,
                           ex_wsel, ex_aluout, ex_storedata};
            m_waiting = !m_halted && m_mem.v && (m_mem.rd || m_mem.wr);
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge CLK) begin
        chk("mem_stall", mem_stall, m_halted || (m_waiting && !dhit));
        chk("dmemREN",   dmemREN,   m_waiting && m_mem.rd);
        chk("dmemWEN",   dmemWEN,   m_waiting && m_mem.wr);
        chk("dmemaddr",  dmemaddr,  m_waiting ? m_mem.alu : 32'd0);
        chk("dmemstore", dmemstore, m_waiting ? m_mem.st : 32'd0);
        chk("MEMwsel",   MEMwsel,   m_mem.sel);
        chk("MEMRegWr",  MEMRegWr,  m_mem.v && m_mem.rw && !m_mem.m2r);
        chk("MEMresult", MEMresult, m_mem.alu);
        chk("WBwsel",    WBwsel,    m_wb.sel);
        chk("WBRegWr",   WBRegWr,   m_wb.v && m_wb.rw);
        chk("wb_wdat",   wb_wdat,   m_wb.wd);
        chk("wb_halt",   wb_halt,   m_halted);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic rd,
                          input logic wr, input logic h, input logic [4:0] sel,
                          input logic [31:0] alu, input logic [31:0] st);
        ex_valid = v; ex_RegWr = rw; ex_MemToReg = m2r; ex_dREN = rd; ex_dWEN = wr;
        ex_halt = h; ex_wsel = sel; ex_aluout = alu; ex_storedata = st;
    endtask

    task automatic bubble();
        set_ex(0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        nRST = 1'b1;
        bubble();
        flush = 0; dhit = 0; dmemload = '0;
        #2 nRST = 1'b0;
        step();
        mid();
        chk("reset dmemREN", dmemREN, 0);
        chk("reset WBRegWr", WBRegWr, 0);
        chk("reset wb_halt", wb_halt, 0);
        step();
        nRST = 1'b1;
        step();

        // ALU op
        set_ex(1, 1, 0, 0, 0, 0, 5'd5, 32'h10, 32'd0);
        step(); bubble();
        mid();
        chk("alu MEMwsel", MEMwsel, 5);
        chk("alu MEMRegWr", MEMRegWr, 1);
        chk("alu MEMresult", MEMresult, 32'h10);
        step(); mid();
        chk("alu WBwsel", WBwsel, 5);
        chk("alu WBRegWr", WBRegWr, 1);
        chk("alu wb_wdat", wb_wdat, 32'h10);
        step();

        // Load with dhit on third access cycle
        set_ex(1, 1, 1, 1, 0, 0, 5'd9, 32'h100, 32'd0);
        step(); bubble();
        mid();
        chk("ld1 dmemREN", dmemREN, 1); chk("ld1 addr", dmemaddr, 32'h100);
        chk("ld1 MEMRegWr", MEMRegWr, 0); chk("ld1 stall", mem_stall, 1);
        step(); mid();
        chk("ld2 dmemREN", dmemREN, 1); chk("ld2 stall", mem_stall, 1);
        step(); dhit = 1; dmemload = 32'hDEADBEEF;
        mid();
        chk("ld3 dmemREN", dmemREN, 1); chk("ld3 stall", mem_stall, 0);
        chk("ld3 MEMRegWr", MEMRegWr, 0);
        step(); dhit = 0;
        mid();
        chk("ld wb_wdat", wb_wdat, 32'hDEADBEEF); chk("ld WBRegWr", WBRegWr, 1);
        chk("ld WBwsel", WBwsel, 9); chk("ld dropped REN", dmemREN, 0);
        step();

        // Store with immediate hit
        set_ex(1, 0, 0, 0, 1, 0, 5'd3, 32'h40, 32'hCAFE);
        step(); bubble(); dhit = 1;
        mid();
        chk("st dmemWEN", dmemWEN, 1); chk("st dmemstore", dmemstore, 32'hCAFE);
        chk("st addr", dmemaddr, 32'h40); chk("st stall", mem_stall, 0);
        step(); dhit = 0;
        mid();
        chk("st WBRegWr", WBRegWr, 0); chk("st dropped WEN", dmemWEN, 0);
        step();

        // Back-to-back loads, each hitting immediately
        set_ex(1, 1, 1, 1, 0, 0, 5'd1, 32'h200, 32'd0);
        step();
        set_ex(1, 1, 1, 1, 0, 0, 5'd2, 32'h204, 32'd0); dhit = 1; dmemload = 32'h11;
        mid();
        chk("b2b addr0", dmemaddr, 32'h200); chk("b2b stall0", mem_stall, 0);
        step();
        set_ex(1, 1, 1, 1, 0, 0, 5'd3, 32'h208, 32'd0); dmemload = 32'h22;
        mid();
        chk("b2b addr1", dmemaddr, 32'h204); chk("b2b REN1", dmemREN, 1);
        chk("b2b WBwsel", WBwsel, 1); chk("b2b wdat0", wb_wdat, 32'h11);
        step(); bubble(); dmemload = 32'h33;
        mid();
        chk("b2b addr2", dmemaddr, 32'h208); chk("b2b wdat1", wb_wdat, 32'h22);
        step(); dhit = 0;
        mid();
        chk("b2b REN end", dmemREN, 0); chk("b2b wdat2", wb_wdat, 32'h33);
        step();

        // Load stalls an ALU op behind it; dhit in IDLE is ignored afterwards
        set_ex(1, 1, 1, 1, 0, 0, 5'd6, 32'h180, 32'd0);
        step();
        set_ex(1, 1, 0, 0, 0, 0, 5'd4, 32'h44, 32'd0);
        mid(); chk("hold stall", mem_stall, 1);
        step(); dhit = 1; dmemload = 32'h55;
        mid(); chk("hold MEMwsel", MEMwsel, 6);
        step(); bubble();
        mid();
        chk("hold alu MEMwsel", MEMwsel, 4); chk("hold alu MEMRegWr", MEMRegWr, 1);
        chk("hold REN idle", dmemREN, 0); chk("hold ld wdat", wb_wdat, 32'h55);
        step();
        mid();
        chk("idle dhit ignored", wb_wdat, 32'h44); chk("idle dhit stall", mem_stall, 0);
        step(); dhit = 0;

        // Flush
        set_ex(1, 1, 0, 0, 0, 0, 5'd7, 32'h77, 32'd0); flush = 1;
        step(); flush = 0; bubble();
        mid(); chk("flush MEMRegWr", MEMRegWr, 0);
        step(); mid(); chk("flush WBRegWr", WBRegWr, 0);
        step();

        // Halt, then a load that must never be issued
        set_ex(1, 0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0);
        step();
        set_ex(1, 1, 1, 1, 0, 0, 5'd8, 32'h300, 32'd0);
        mid(); chk("pre halt", wb_halt, 0);
        step();
        mid();
        chk("halt wb_halt", wb_halt, 1); chk("halt stall", mem_stall, 1);
        chk("halt REN", dmemREN, 0);
        dhit = 1;
        repeat (3) step();
        mid();
        chk("halt sticky", wb_halt, 1); chk("halt REN later", dmemREN, 0);
        chk("halt stall later", mem_stall, 1);
        step(); dhit = 0; bubble();

        // Reset asserted in the middle of an access
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        set_ex(1, 1, 1, 1, 0, 0, 5'd10, 32'h500, 32'd0);
        step(); bubble();
        mid(); chk("rst pre REN", dmemREN, 1);
        #2 nRST = 1'b0;
        #1;
        chk("rst async REN", dmemREN, 0);
        chk("rst async stall", mem_stall, 0);
        chk("rst async addr", dmemaddr, 0);
        chk("rst async MEMresult", MEMresult, 0);
        chk("rst async MEMwsel", MEMwsel, 0);
        chk("rst async wb_halt", wb_halt, 0);
        step();
        nRST = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
